// File: rtl/seq_tx_pkg.sv
// Shared types and defaults for the serial pattern transmitter.
// The default pattern is the sequence the on-chip detector looks for.
package seq_tx_pkg;

    localparam int DEF_PAT_W = 4;
    localparam int DEF_DIV_W = 8;
    localparam int DEF_REP_W = 4;

    localparam logic [3:0] DEF_PATTERN = 4'b1001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/seq_pattern_tx_if.sv
// Control and serial-output bundle of the pattern transmitter.
// Handshake: start is a level request, accepted only at a clock edge where the transmitter is idle and abort is low.
interface seq_pattern_tx_if #(
    parameter int PAT_W = seq_tx_pkg::DEF_PAT_W,
    parameter int DIV_W = seq_tx_pkg::DEF_DIV_W,
    parameter int REP_W = seq_tx_pkg::DEF_REP_W
);
    logic             start;
    logic             abort;
    logic [PAT_W-1:0] pattern;
    logic [DIV_W-1:0] bit_div;
    logic [REP_W-1:0] repeat_n;
    logic             x_out;
    logic             bit_strobe;
    logic             busy;
    logic             done;
    logic [REP_W-1:0] rep_left;

    modport master (
        output start, abort, pattern, bit_div, repeat_n,
        input  x_out, bit_strobe, busy, done, rep_left
    );

    modport slave (
        input  start, abort, pattern, bit_div, repeat_n,
        output x_out, bit_strobe, busy, done, rep_left
    );
endinterface

// File: rtl/seq_pattern_tx_bit_period_timer.sv
// Loadable down-counter that paces the bit period; tick is registered and
// marks the last cycle of each period.
module bit_period_timer #(
    parameter int DIV_W = seq_tx_pkg::DEF_DIV_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [DIV_W-1:0] load_val,
    output logic             tick
);
    logic [DIV_W-1:0] count_q, count_d;
    logic [DIV_W-1:0] period_q, period_d;
    logic             tick_q, tick_d;

    always_comb begin
        count_d  = count_q;
        period_d = period_q;
        if (load) begin
            count_d  = load_val;
            period_d = load_val;
        end else if (en) begin
            count_d = (count_q == '0) ? period_q : count_q - 1'b1;
        end
        // tick only while running, so it drops as soon as the owner stops enabling
        tick_d = (load || en) && (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q  <= '0;
            period_q <= '0;
            tick_q   <= 1'b0;
        end else begin
            count_q  <= count_d;
            period_q <= period_d;
            tick_q   <= tick_d;
        end
    end

    assign tick = tick_q;
endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a latched pattern MSB-first for a number
// of back-to-back repetitions, pacing each bit with bit_period_timer.
module seq_pattern_tx
    import seq_tx_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int DIV_W = DEF_DIV_W,
    parameter int REP_W = DEF_REP_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    seq_pattern_tx_if.slave        bus,
    output state_t                 dbg_state
);
    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic             x_q, x_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tmr_load, tmr_en, tmr_tick;

    bit_period_timer #(.DIV_W(DIV_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .en       (tmr_en),
        .load_val (bus.bit_div),
        .tick     (tmr_tick)
    );

    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        idx_d    = idx_q;
        rep_d    = rep_q;
        x_d      = x_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;

        case (state_q)
            IDLE: begin
                x_d    = 1'b0;
                busy_d = 1'b0;
                rep_d  = '0;
                if (bus.start) begin
                    state_d  = SHIFT;
                    pat_d    = bus.pattern;
                    idx_d    = IDX_W'(PAT_W - 1);
                    rep_d    = (bus.repeat_n == '0) ? REP_W'(1) : bus.repeat_n;
                    x_d      = bus.pattern[PAT_W-1];
                    busy_d   = 1'b1;
                    tmr_load = 1'b1;
                end
            end
            SHIFT: begin
                tmr_en = 1'b1;
                if (tmr_tick) begin
                    if (idx_q != '0) begin
                        idx_d = idx_q - 1'b1;
                        x_d   = pat_q[idx_q - 1'b1];
                    end else if (rep_q > REP_W'(1)) begin
                        // next repetition starts on the very next cycle, no gap
                        rep_d = rep_q - 1'b1;
                        idx_d = IDX_W'(PAT_W - 1);
                        x_d   = pat_q[PAT_W-1];
                    end else begin
                        state_d = DONE;
                        x_d     = 1'b0;
                        busy_d  = 1'b0;
                        rep_d   = '0;
                        done_d  = 1'b1;
                        tmr_en  = 1'b0;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                x_d     = 1'b0;
                busy_d  = 1'b0;
                rep_d   = '0;
            end
            default: begin
                state_d = IDLE;
                x_d     = 1'b0;
                busy_d  = 1'b0;
                rep_d   = '0;
            end
        endcase

        // abort wins over everything, including a simultaneous start
        if (bus.abort) begin
            state_d  = IDLE;
            x_d      = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            rep_d    = '0;
            tmr_load = 1'b0;
            tmr_en   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pat_q   <= PAT_W'(DEF_PATTERN);
            idx_q   <= '0;
            rep_q   <= '0;
            x_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            idx_q   <= idx_d;
            rep_q   <= rep_d;
            x_q     <= x_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.x_out      = x_q;
    assign bus.bit_strobe = tmr_tick;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.rep_left   = rep_q;
    assign dbg_state      = state_q;
endmodule
